spatz_l1d_maint_ctrl: RTL

- Per-cache-controller maintenance sequencer; sits directly downstream of the cluster peripheral's L1D instruction interface. One instance per cache controller, driving that controller's bit of the peripheral's l1d_insn_ready_i.
- Accepts flush/invalidate commands and walks every set and way that is not reserved as SPM, writing back dirty lines and updating tag state.
- Returns exactly one ready pulse per accepted command, which releases that controller's lock bit in the peripheral.

---
 rtl/spatz_l1d_maint_pkg.sv | 45 ++++
 rtl/spatz_l1d_maint_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spatz_l1d_maint_pkg.sv
// ----------------------------------------------------------------------------
// spatz_l1d_maint_pkg
// Shared types for the L1D maintenance sequencer:
//   insn_e    - command encoding as seen on the peripheral's L1D instruction bus
//   state_e   - maintenance FSM states
//   tag_req_t - non-address part of a tag-array request (read/write + new bits)
// Helper functions classify which commands write back and which invalidate.
// ----------------------------------------------------------------------------
package spatz_l1d_maint_pkg;

   typedef enum logic [1:0] {
      INSN_NOP        = 2'b00,
      INSN_INVALIDATE = 2'b01,
      INSN_FLUSH      = 2'b10,
      INSN_FLUSH_INV  = 2'b11
   } insn_e;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      RSP,
      WB_REQ,
      WB_WAIT,
      WRITE,
      NEXT,
      DONE
   } state_e;

   // Address (set/way) comes straight from the iterator registers, so only the
   // command-dependent bits are bundled here.
   typedef struct packed {
      logic write;
      logic wvalid;
      logic wdirty;
   } tag_req_t;

   function automatic logic insn_writes_back(insn_e insn);
      return (insn == INSN_FLUSH) || (insn == INSN_FLUSH_INV);
   endfunction

   function automatic logic insn_invalidates(insn_e insn);
      return (insn == INSN_INVALIDATE) || (insn == INSN_FLUSH_INV);
   endfunction

endpackage

// File: rtl/spatz_l1d_maint_ctrl.sv
// ----------------------------------------------------------------------------
// spatz_l1d_maint_ctrl
// Per-controller L1D maintenance sequencer. Accepts flush / invalidate
// commands, walks every non-SPM set/way, writes back dirty lines and updates
// tag state, then returns exactly one insn_ready_o pulse per command.
//
// Ports
//   clk_i, rst_ni                      clock, async active-low reset
//   insn_i, insn_valid_i               command and single-cycle strobe
//   spm_ways_i                         number of top ways reserved as SPM
//   insn_ready_o                       single-cycle done pulse
//   maint_busy_o                       high from accept through done
//   tag_req_*                          tag-array request (read / write)
//   tag_wvalid_o, tag_wdirty_o         new tag bits for write requests
//   tag_rsp_*                          tag-array read response (1 cycle after)
//   wb_req_*, wb_set_o/way_o/tag_o     writeback request and payload
//   wb_done_i                          writeback completion pulse
//   wb_count_o                         writebacks of current/last command
//                                      (only with SPATZ_L1D_MAINT_STATS_EN)
//
// Handshakes: a request transfers on a cycle where valid and ready are both
// high; valid, once raised, stays high with a stable payload until that
// transfer, and valid never waits on ready.
//
// Optional build macro: SPATZ_L1D_MAINT_STATS_EN adds the writeback counter.
// ----------------------------------------------------------------------------
module spatz_l1d_maint_ctrl
   import spatz_l1d_maint_pkg::*;
#(
   parameter int unsigned NumSets  = 128,
   parameter int unsigned NumWays  = 4,
   parameter int unsigned TagWidth = 20,
   parameter int unsigned SetWidth = $clog2(NumSets),
   parameter int unsigned WayWidth = $clog2(NumWays)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [1:0]          insn_i,
   input  logic                insn_valid_i,
   input  logic [WayWidth:0]   spm_ways_i,
   output logic                insn_ready_o,
   output logic                maint_busy_o,
   output logic                tag_req_valid_o,
   input  logic                tag_req_ready_i,
   output logic                tag_req_write_o,
   output logic [SetWidth-1:0] tag_req_set_o,
   output logic [WayWidth-1:0] tag_req_way_o,
   output logic                tag_wvalid_o,
   output logic                tag_wdirty_o,
   input  logic                tag_rsp_valid_i,
   input  logic                tag_rsp_vld_i,
   input  logic                tag_rsp_dirty_i,
   input  logic [TagWidth-1:0] tag_rsp_tag_i,
   output logic                wb_req_valid_o,
   input  logic                wb_req_ready_i,
   output logic [SetWidth-1:0] wb_set_o,
   output logic [WayWidth-1:0] wb_way_o,
   output logic [TagWidth-1:0] wb_tag_o,
   input  logic                wb_done_i
`ifdef SPATZ_L1D_MAINT_STATS_EN
   ,
   output logic [31:0]         wb_count_o
`endif
);

   state_e                state_q, state_d;
   insn_e                 insn_q;
   logic [WayWidth:0]     spm_q;
   logic [SetWidth-1:0]   set_q;
   logic [WayWidth-1:0]   way_q;
   logic [TagWidth-1:0]   wb_tag_q;
   tag_req_t              tag_req_q;
   logic                  tag_req_valid_q;
   logic                  wb_req_valid_q;
   logic                  ready_q;
   logic                  busy_q;

   insn_e                 insn_in;
   logic                  accept;
   logic                  all_spm;
   logic [WayWidth:0]     way_limit;
   logic                  last_way;
   logic                  last_set;

   assign insn_in   = insn_e'(insn_i);
   assign accept    = (state_q == IDLE) && insn_valid_i;
   assign all_spm   = (spm_ways_i >= (WayWidth+1)'(NumWays));
   // Ways above the SPM boundary are skipped; the limit uses the SPM count
   // latched at accept so later changes on spm_ways_i cannot disturb a walk.
   assign way_limit = (WayWidth+1)'(NumWays) - spm_q;
   assign last_way  = ({1'b0, way_q} == (way_limit - (WayWidth+1)'(1)));
   assign last_set  = (set_q == SetWidth'(NumSets - 1));

   // -------------------------------------------------------------------------
   // FSM state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (insn_valid_i) begin
               if (insn_in == INSN_NOP || all_spm) state_d = DONE;
               else                                state_d = READ;
            end
         end
         READ: begin
            if (tag_req_ready_i) state_d = RSP;
         end
         RSP: begin
            if (tag_rsp_valid_i) begin
               if (insn_writes_back(insn_q) && tag_rsp_vld_i && tag_rsp_dirty_i)
                  state_d = WB_REQ;
               else if (insn_invalidates(insn_q) && tag_rsp_vld_i)
                  state_d = WRITE;
               else
                  state_d = NEXT;
            end
         end
         WB_REQ: begin
            if (wb_req_ready_i) state_d = WB_WAIT;
         end
         WB_WAIT: begin
            if (wb_done_i) state_d = WRITE;
         end
         WRITE: begin
            if (tag_req_ready_i) state_d = NEXT;
         end
         NEXT: begin
            if (last_way && last_set) state_d = DONE;
            else                      state_d = READ;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Iterator, latched command and registered outputs. Request valids are
   // computed from the next state so they are flop outputs that line up
   // exactly with the state that owns them.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         insn_q          <= INSN_NOP;
         spm_q           <= '0;
         set_q           <= '0;
         way_q           <= '0;
         wb_tag_q        <= '0;
         tag_req_q       <= '0;
         tag_req_valid_q <= 1'b0;
         wb_req_valid_q  <= 1'b0;
         ready_q         <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         if (accept && insn_in != INSN_NOP) begin
            insn_q <= insn_in;
            spm_q  <= spm_ways_i;
            set_q  <= '0;
            way_q  <= '0;
         end else if (state_q == NEXT && state_d == READ) begin
            if (last_way) begin
               way_q <= '0;
               set_q <= set_q + SetWidth'(1);
            end else begin
               way_q <= way_q + WayWidth'(1);
            end
         end

         if (state_q == RSP && tag_rsp_valid_i) wb_tag_q <= tag_rsp_tag_i;

         tag_req_valid_q  <= (state_d == READ) || (state_d == WRITE);
         tag_req_q.write  <= (state_d == WRITE);
         // FLUSH keeps the line resident; every invalidating command clears it.
         tag_req_q.wvalid <= (state_d == WRITE) && (insn_q == INSN_FLUSH);
         tag_req_q.wdirty <= 1'b0;
         wb_req_valid_q   <= (state_d == WB_REQ);

         // Ready is issued the cycle after DONE; busy falls in that same cycle.
         ready_q <= (state_q == DONE);
         if (accept && insn_in != INSN_NOP) busy_q <= 1'b1;
         else if (state_q == DONE)          busy_q <= 1'b0;
      end
   end

   assign insn_ready_o    = ready_q;
   assign maint_busy_o    = busy_q;
   assign tag_req_valid_o = tag_req_valid_q;
   assign tag_req_write_o = tag_req_q.write;
   assign tag_wvalid_o    = tag_req_q.wvalid;
   assign tag_wdirty_o    = tag_req_q.wdirty;
   assign tag_req_set_o   = set_q;
   assign tag_req_way_o   = way_q;
   assign wb_req_valid_o  = wb_req_valid_q;
   assign wb_set_o        = set_q;
   assign wb_way_o        = way_q;
   assign wb_tag_o        = wb_tag_q;

`ifdef SPATZ_L1D_MAINT_STATS_EN
   logic [31:0] wb_count_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wb_count_q <= '0;
      end else if (accept) begin
         wb_count_q <= '0;
      end else if (wb_req_valid_q && wb_req_ready_i && wb_count_q != '1) begin
         wb_count_q <= wb_count_q + 32'd1;
      end
   end

   assign wb_count_o = wb_count_q;
`endif

   // A command strobe is only meaningful in IDLE; anything else is dropped.
   insn_outside_idle: assert property (
      @(posedge clk_i) disable iff (!rst_ni) insn_valid_i |-> (state_q == IDLE));

endmodule
